// File: rtl/vqueue_unpack_pkg.sv
// Shared video definitions: queue word width, unpacker state encoding and
// the pixel value emitted when the queue runs dry.
package vqueue_unpack_pkg;

    localparam int QW = 32;

    typedef enum logic {
        EMPTY = 1'b0,
        RUN   = 1'b1
    } state_e;

    localparam logic [QW-1:0] UF_PIXEL = '0;

    function automatic int calc_ppw(input int bpp);
        return QW / bpp;
    endfunction

endpackage

// File: rtl/vqueue_unpack_if.sv
// Video queue read port plus pixel-side timing/output signals of the unpacker.
interface vqueue_unpack_if
    import vqueue_unpack_pkg::*;
#(
    parameter int bpp = 1
) ();

    // rd_en is a single-cycle pop that fires only in a cycle where q is
    // captured; q is then unusable for one settle cycle after the pop.
    logic [QW-1:0] q;
    logic          empty;
    logic          rd_en;
    logic          de;
    logic          frame_start;
    logic [bpp-1:0] pixel;
    logic          pixel_valid;
    logic          underflow;
    logic [15:0]   underflow_count;

    modport master (
        output q, empty, de, frame_start,
        input  rd_en, pixel, pixel_valid, underflow, underflow_count
    );

    modport slave (
        input  q, empty, de, frame_start,
        output rd_en, pixel, pixel_valid, underflow, underflow_count
    );

endinterface

// File: rtl/vqueue_unpack.sv
// Pops 32-bit words from the video queue and serialises them into bpp-wide
// pixels while de is high, substituting a zero pixel and counting underflows.
module vqueue_unpack
    import vqueue_unpack_pkg::*;
#(
    parameter int bpp       = 1,
    parameter bit msb_first = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    vqueue_unpack_if.slave  vq,
    output state_e          dbg_state_o
);

    localparam int ppw = calc_ppw(bpp);
    localparam int CW  = $clog2(ppw);

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [QW-1:0]   sr_q, sr_d;
    logic            settle_q;
    logic [bpp-1:0]  pixel_q, pixel_d;
    logic            pv_q, pv_d;
    logic            uf_q, uf_d;
    logic [15:0]     ufc_q, ufc_d;
    logic            rd_c;

    logic            word_ok;
    logic            last;
    logic [bpp-1:0]  slice;
    logic [QW-1:0]   sr_next;

    // q is only trusted while non-empty and not in the settle cycle after a pop.
    assign word_ok = !vq.empty && !settle_q;
    assign last    = (count_q == CW'(ppw - 1));
    assign slice   = msb_first ? sr_q[QW-1 -: bpp] : sr_q[bpp-1:0];
    assign sr_next = msb_first ? (sr_q << bpp) : (sr_q >> bpp);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        sr_d    = sr_q;
        pixel_d = pixel_q;
        pv_d    = 1'b0;
        uf_d    = uf_q;
        ufc_d   = ufc_q;
        rd_c    = 1'b0;

        if (vq.frame_start) begin
            state_d = EMPTY;
            count_d = '0;
            uf_d    = 1'b0;
            ufc_d   = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (vq.de) begin
                        pixel_d = UF_PIXEL[bpp-1:0];
                        pv_d    = 1'b1;
                        uf_d    = 1'b1;
                        ufc_d   = (ufc_q == 16'hFFFF) ? ufc_q : ufc_q + 16'd1;
                    end
                    if (word_ok) begin
                        sr_d    = vq.q;
                        rd_c    = 1'b1;
                        count_d = '0;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (vq.de) begin
                        pixel_d = slice;
                        pv_d    = 1'b1;
                        if (!last) begin
                            sr_d    = sr_next;
                            count_d = count_q + 1'b1;
                        end else if (word_ok) begin
                            sr_d    = vq.q;
                            rd_c    = 1'b1;
                            count_d = '0;
                        end else begin
                            state_d = EMPTY;
                        end
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            count_q  <= '0;
            sr_q     <= '0;
            settle_q <= 1'b0;
            pixel_q  <= '0;
            pv_q     <= 1'b0;
            uf_q     <= 1'b0;
            ufc_q    <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            sr_q     <= sr_d;
            settle_q <= rd_c;
            pixel_q  <= pixel_d;
            pv_q     <= pv_d;
            uf_q     <= uf_d;
            ufc_q    <= ufc_d;
        end
    end

    // Gate with rst_n so the pop strobe drops the instant reset asserts.
    assign vq.rd_en           = rd_c & rst_n;
    assign vq.pixel           = pixel_q;
    assign vq.pixel_valid     = pv_q;
    assign vq.underflow       = uf_q;
    assign vq.underflow_count = ufc_q;
    assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_vqueue_unpack.sv
// Bench for vqueue_unpack: four configurations, each fed by a small queue model
// whose head reads as garbage during the settle cycle after a pop.
module tb_vqueue_unpack;
  import vqueue_unpack_pkg::*;

  localparam int NI = 4;

  typedef struct {
    int          k;
    int          np;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        de;
    logic        fs;
    logic        x_rd;
    logic        x_pv;
    logic [15:0] x_pix;
    logic        x_uf;
    logic [15:0] x_ufc;
    string       nm;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] q_d [NI];
  logic        em_d [NI];
  logic        de_d [NI];
  logic        fs_d [NI];
  logic        rd [NI];
  logic        pv [NI];
  logic        uf [NI];
  logic [15:0] pix [NI];
  logic [15:0] ufc [NI];
  state_e      st [NI];

  logic [31:0] qm [NI][8];
  int          qh [NI];
  int          qt [NI];
  logic        sm [NI];

  int n_chk = 0;
  int n_pass = 0;
  vec_t tbl[$];

  // ---------------- clock / DUTs ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  vqueue_unpack_if #(.bpp(1)) if0();
  vqueue_unpack_if #(.bpp(8)) if1();
  vqueue_unpack_if #(.bpp(4)) if2();
  vqueue_unpack_if #(.bpp(2)) if3();

  assign if0.q = q_d[0]; assign if0.empty = em_d[0]; assign if0.de = de_d[0]; assign if0.frame_start = fs_d[0];
  assign if1.q = q_d[1]; assign if1.empty = em_d[1]; assign if1.de = de_d[1]; assign if1.frame_start = fs_d[1];
  assign if2.q = q_d[2]; assign if2.empty = em_d[2]; assign if2.de = de_d[2]; assign if2.frame_start = fs_d[2];
  assign if3.q = q_d[3]; assign if3.empty = em_d[3]; assign if3.de = de_d[3]; assign if3.frame_start = fs_d[3];

  assign rd[0] = if0.rd_en; assign pv[0] = if0.pixel_valid; assign uf[0] = if0.underflow;
  assign rd[1] = if1.rd_en; assign pv[1] = if1.pixel_valid; assign uf[1] = if1.underflow;
  assign rd[2] = if2.rd_en; assign pv[2] = if2.pixel_valid; assign uf[2] = if2.underflow;
  assign rd[3] = if3.rd_en; assign pv[3] = if3.pixel_valid; assign uf[3] = if3.underflow;
  assign pix[0] = 16'(if0.pixel); assign ufc[0] = if0.underflow_count;
  assign pix[1] = 16'(if1.pixel); assign ufc[1] = if1.underflow_count;
  assign pix[2] = 16'(if2.pixel); assign ufc[2] = if2.underflow_count;
  assign pix[3] = 16'(if3.pixel); assign ufc[3] = if3.underflow_count;

  vqueue_unpack #(.bpp(1), .msb_first(1'b1)) u0 (.clk(clk), .rst_n(rst_n), .vq(if0), .dbg_state_o(st[0]));
  vqueue_unpack #(.bpp(8), .msb_first(1'b0)) u1 (.clk(clk), .rst_n(rst_n), .vq(if1), .dbg_state_o(st[1]));
  vqueue_unpack #(.bpp(4), .msb_first(1'b1)) u2 (.clk(clk), .rst_n(rst_n), .vq(if2), .dbg_state_o(st[2]));
  vqueue_unpack #(.bpp(2), .msb_first(1'b1)) u3 (.clk(clk), .rst_n(rst_n), .vq(if3), .dbg_state_o(st[3]));

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic refresh(input int k);
    q_d[k]  = sm[k] ? 32'hBAD0_BAD0 : qm[k][qh[k] % 8];
    em_d[k] = (qh[k] == qt[k]);
  endtask

  task automatic push(input int k, input logic [31:0] w);
    qm[k][qt[k] % 8] = w;
    qt[k]++;
    refresh(k);
  endtask

  // Queue model: pops on a sampled rd_en, head unusable for one cycle after.
  always @(posedge clk) begin : qmodel
    logic popv [NI];
    for (int k = 0; k < NI; k++) popv[k] = rd[k];
    #1;
    for (int k = 0; k < NI; k++) begin
      if (popv[k]) begin
        chk("pop_nonempty", 32'(em_d[k]), 32'd0);
        qh[k]++;
      end
      sm[k] = popv[k];
      refresh(k);
    end
  end

  function automatic void add(input int k, input int np, input logic [31:0] w0, input logic [31:0] w1,
                              input logic de, input logic fs, input logic x_rd, input logic x_pv,
                              input logic [15:0] x_pix, input logic x_uf, input logic [15:0] x_ufc,
                              input string nm);
    vec_t v;
    v.k = k; v.np = np; v.w0 = w0; v.w1 = w1; v.de = de; v.fs = fs;
    v.x_rd = x_rd; v.x_pv = x_pv; v.x_pix = x_pix; v.x_uf = x_uf; v.x_ufc = x_ufc; v.nm = nm;
    tbl.push_back(v);
  endfunction

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    if (v.np > 0) push(v.k, v.w0);
    if (v.np > 1) push(v.k, v.w1);
    for (int k = 0; k < NI; k++) begin de_d[k] = 1'b0; fs_d[k] = 1'b0; end
    de_d[v.k] = v.de;
    fs_d[v.k] = v.fs;
    #1 chk({v.nm, "_rd"}, 32'(rd[v.k]), 32'(v.x_rd));
    @(posedge clk);
    #1;
    chk({v.nm, "_pv"},  32'(pv[v.k]),  32'(v.x_pv));
    chk({v.nm, "_pix"}, 32'(pix[v.k]), 32'(v.x_pix));
    chk({v.nm, "_uf"},  32'(uf[v.k]),  32'(v.x_uf));
    chk({v.nm, "_ufc"}, 32'(ufc[v.k]), 32'(v.x_ufc));
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_chk);
    $fatal(1, "time limit");
  end

  // ---------------- test ----------------
  initial begin : main
    logic [15:0] e8 [8];
    logic [15:0] sg [8];
    logic [15:0] p6c [4];
    logic [15:0] pe4 [4];
    logic [15:0] p;
    e8  = '{16'h11, 16'h22, 16'h33, 16'h44, 16'h55, 16'h66, 16'h77, 16'h88};
    sg  = '{16'h0A, 16'h0B, 16'h0C, 16'h0D, 16'h1A, 16'h1B, 16'h1C, 16'h1D};
    p6c = '{16'd1, 16'd2, 16'd3, 16'd0};
    pe4 = '{16'd3, 16'd2, 16'd1, 16'd0};

    // bpp=1 msb-first: two words, 64 seamless pixels, pops at prime and pixel 32
    add(0, 2, 32'h8000_0001, 32'hFFFF_0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 16'd0, "t1_prime");
    for (int i = 0; i < 64; i++) begin
      p = (i == 0 || i == 31 || (i >= 32 && i < 48)) ? 16'd1 : 16'd0;
      add(0, 0, 0, 0, 1'b1, 1'b0, (i == 31), 1'b1, p, 1'b0, 16'd0, "t1_pix");
    end
    // bpp=8 lsb-first: 11,22,33,44 then refill on the 4th de
    add(1, 1, 32'h4433_2211, 0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 16'd0, "t2_prime");
    for (int i = 0; i < 8; i++)
      add(1, (i == 0) ? 1 : 0, 32'h8877_6655, 0, 1'b1, 1'b0, (i == 3), 1'b1, e8[i], 1'b0, 16'd0, "t2_pix");
    // settle guard: second word arrives in the settle cycle after a pop
    add(1, 1, 32'h0D0C_0B0A, 0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h88, 1'b0, 16'd0, "sg_cap");
    add(1, 1, 32'h1D1C_1B1A, 0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h88, 1'b0, 16'd0, "sg_settle");
    for (int i = 0; i < 8; i++)
      add(1, 0, 0, 0, 1'b1, 1'b0, (i == 3), 1'b1, sg[i], 1'b0, 16'd0, "sg_pix");
    // bpp=4 underflow: 8 data pixels then 4 zero pixels, cleared by frame_start
    add(2, 1, 32'h1234_5678, 0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 16'd0, "uf_prime");
    for (int i = 0; i < 12; i++)
      add(2, 0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1, (i < 8) ? 16'(i + 1) : 16'd0,
          (i >= 8), (i >= 8) ? 16'(i - 7) : 16'd0, "uf_pix");
    add(2, 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 16'd0, "uf_clear");
    // bpp=2 frame_start mid-word: drop rest of word, next word starts clean
    add(3, 2, 32'h6C6C_6C6C, 32'hE4E4_E4E4, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 16'd0, "fs_prime");
    for (int i = 0; i < 5; i++)
      add(3, 0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1, p6c[i % 4], 1'b0, 16'd0, "fs_pix_a");
    add(3, 0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1, 1'b0, 16'd0, "fs_mid");
    add(3, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1, 1'b0, 16'd0, "fs_recap");
    for (int i = 0; i < 4; i++)
      add(3, 0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1, pe4[i], 1'b0, 16'd0, "fs_pix_b");

    // reset state
    rst_n = 1'b1;
    for (int k = 0; k < NI; k++) begin
      de_d[k] = 1'b0; fs_d[k] = 1'b0; qh[k] = 0; qt[k] = 0; sm[k] = 1'b0;
      for (int j = 0; j < 8; j++) qm[k][j] = '0;
      refresh(k);
    end
    #1 rst_n = 1'b0;
    #2;
    for (int k = 0; k < NI; k++) begin
      chk("rst_rd", 32'(rd[k]), 32'd0);
      chk("rst_pv", 32'(pv[k]), 32'd0);
      chk("rst_pix", 32'(pix[k]), 32'd0);
      chk("rst_uf", 32'(uf[k]), 32'd0);
      chk("rst_ufc", 32'(ufc[k]), 32'd0);
      chk("rst_state", 32'(st[k]), 32'(EMPTY));
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    foreach (tbl[i]) run_vec(tbl[i]);

    // underflow counter saturation on the bpp=4 instance
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin de_d[k] = 1'b0; fs_d[k] = 1'b0; end
    de_d[2] = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_fffe", 32'(ufc[2]), 32'h0000_FFFE);
    chk("sat_uf", 32'(uf[2]), 32'd1);
    @(posedge clk);
    #1 chk("sat_ffff", 32'(ufc[2]), 32'h0000_FFFF);
    repeat (70000 - 65535) @(posedge clk);
    #1;
    chk("sat_hold", 32'(ufc[2]), 32'h0000_FFFF);
    chk("sat_pv", 32'(pv[2]), 32'd1);
    chk("sat_pix", 32'(pix[2]), 32'd0);

    // asynchronous reset mid-run, while a pop is pending on instance 0
    @(negedge clk);
    push(0, 32'h5555_AAAA);
    #1 chk("arst_pre_rd", 32'(rd[0]), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_rd", 32'(rd[0]), 32'd0);
    chk("arst_pv", 32'(pv[2]), 32'd0);
    chk("arst_uf", 32'(uf[2]), 32'd0);
    chk("arst_ufc", 32'(ufc[2]), 32'd0);
    chk("arst_pix", 32'(pix[1]), 32'd0);
    chk("arst_state", 32'(st[3]), 32'(EMPTY));
    @(negedge clk) rst_n = 1'b1;
    #1 chk("arst_reprime_rd", 32'(rd[0]), 32'd1);
    @(posedge clk);
    #2;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
